// File: rtl/ps2_mouse_pkg.sv
// Shared types, command codes and the init command list for the PS/2 mouse tracker.
// Build option: define PS2_MOUSE_WHEEL_EN for the scroll-wheel (IntelliMouse) variant.
package ps2_mouse_pkg;

  typedef enum logic {OP_WRITE, OP_EXPECT} opcode_t;

  typedef struct packed {
    opcode_t    op;
    logic [7:0] code;
  } cmd_t;

  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic sync;
    logic middle;
    logic right;
    logic left;
  } flags_t;

  typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_B3} pkt_state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] ID_STD       = 8'h00;

`ifdef PS2_MOUSE_WHEEL_EN
  localparam int unsigned INIT_LEN = 21;
  localparam logic [7:0]  ID_WHEEL = 8'h03;
`else
  localparam int unsigned INIT_LEN = 6;
`endif

  function automatic cmd_t wr(input logic [7:0] c);
    return '{op: OP_WRITE, code: c};
  endfunction

  function automatic cmd_t ex(input logic [7:0] c);
    return '{op: OP_EXPECT, code: c};
  endfunction

  function automatic cmd_t init_cmd(input logic [4:0] idx);
    cmd_t c;
    c = ex(RSP_ACK);
    case (idx)
`ifdef PS2_MOUSE_WHEEL_EN
      // Sample-rate knock 200/100/80 unlocks the wheel, then ID should read 03.
      5'd0:  c = wr(CMD_RESET);
      5'd1:  c = ex(RSP_ACK);
      5'd2:  c = ex(RSP_BAT_OK);
      5'd3:  c = ex(ID_STD);
      5'd4:  c = wr(CMD_SET_RATE);
      5'd5:  c = ex(RSP_ACK);
      5'd6:  c = wr(8'hC8);
      5'd7:  c = ex(RSP_ACK);
      5'd8:  c = wr(CMD_SET_RATE);
      5'd9:  c = ex(RSP_ACK);
      5'd10: c = wr(8'h64);
      5'd11: c = ex(RSP_ACK);
      5'd12: c = wr(CMD_SET_RATE);
      5'd13: c = ex(RSP_ACK);
      5'd14: c = wr(8'h50);
      5'd15: c = ex(RSP_ACK);
      5'd16: c = wr(CMD_GET_ID);
      5'd17: c = ex(RSP_ACK);
      5'd18: c = ex(ID_WHEEL);
      5'd19: c = wr(CMD_ENABLE);
      5'd20: c = ex(RSP_ACK);
`else
      5'd0:  c = wr(CMD_RESET);
      5'd1:  c = ex(RSP_ACK);
      5'd2:  c = ex(RSP_BAT_OK);
      5'd3:  c = ex(ID_STD);
      5'd4:  c = wr(CMD_ENABLE);
      5'd5:  c = ex(RSP_ACK);
`endif
      default: c = ex(RSP_ACK);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_mouse_init_seq.sv
// Mouse init sequencer: walks the command list, restarting from entry 0 on a bad reply or timeout.
// List contents depend on PS2_MOUSE_WHEEL_EN (see ps2_mouse_pkg).
import ps2_mouse_pkg::*;

module ps2_mouse_init_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] din,
  output logic       init_done,
  output logic       sync_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [4:0]    idx;
  logic          sent;
  logic [TW-1:0] cnt;
  cmd_t          cur;

  assign cur = init_cmd(idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      sent      <= 1'b0;
      cnt       <= '0;
      wr_ps2    <= 1'b0;
      din       <= '0;
      init_done <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      wr_ps2   <= 1'b0;
      sync_err <= 1'b0;
      if (!init_done) begin
        // Counter first; entry actions below override it on advance/restart.
        if (rx_done_tick || tx_done_tick) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          idx      <= '0;
          sent     <= 1'b0;
          cnt      <= '0;
          sync_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end

        if (cur.op == OP_WRITE) begin
          if (!sent && tx_idle) begin
            wr_ps2 <= 1'b1;
            din    <= cur.code;
            sent   <= 1'b1;
            cnt    <= '0;
          end else if (sent && tx_done_tick) begin
            idx  <= idx + 1'b1;
            sent <= 1'b0;
            cnt  <= '0;
            if (idx == 5'(INIT_LEN - 1)) init_done <= 1'b1;
          end
        end else if (rx_done_tick) begin
          sent <= 1'b0;
          cnt  <= '0;
          if (rx_dout == cur.code) begin
            idx <= idx + 1'b1;
            if (idx == 5'(INIT_LEN - 1)) init_done <= 1'b1;
          end else begin
            idx      <= '0;
            sync_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse controller and clamped cursor tracker; PS2_MOUSE_WHEEL_EN selects 4-byte
// wheel packets and a signed wheel accumulator, otherwise 3-byte packets and wheel = 0.
import ps2_mouse_pkg::*;

module ps2_mouse_tracker #(
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned COORD_W        = 10,
  parameter int unsigned INIT_X         = 100,
  parameter int unsigned INIT_Y         = 100,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_done_tick,
  input  logic [7:0]         rx_dout,
  input  logic               tx_idle,
  input  logic               tx_done_tick,
  output logic               wr_ps2,
  output logic [7:0]         din,
  output logic               init_done,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic [2:0]         buttons,
  output logic               pkt_valid,
  output logic               sync_err,
  output logic [7:0]         wheel
);

  localparam int unsigned SW = COORD_W + 2;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [SW-1:0] X_MAX = SW'(SCREEN_W - 1);
  localparam logic signed [SW-1:0] Y_MAX = SW'(SCREEN_H - 1);
`ifdef PS2_MOUSE_WHEEL_EN
  localparam pkt_state_t LAST_ST = ST_B3;
`else
  localparam pkt_state_t LAST_ST = ST_B2;
`endif

  logic init_err;
  logic run_err;

  ps2_mouse_init_seq #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_init_seq (
    .clk          (clk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .init_done    (init_done),
    .sync_err     (init_err)
  );

  assign sync_err = init_err | run_err;

  pkt_state_t            state;
  flags_t                b0;
  logic [7:0]            b1;
  logic [7:0]            y_byte;
  logic [TW-1:0]         cnt;
  logic                  apply;
  logic signed [SW-1:0]  dx, dy, sum_x, sum_y;
  logic [COORD_W-1:0]    next_x, next_y;

`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0] b2;
  assign y_byte = b2;
`else
  assign y_byte = rx_dout;
`endif

  function automatic logic [COORD_W-1:0] clamp(input logic signed [SW-1:0] v,
                                               input logic signed [SW-1:0] hi);
    if (v < 0)  return '0;
    if (v > hi) return hi[COORD_W-1:0];
    return v[COORD_W-1:0];
  endfunction

  // b0 is only ever latched with its sync bit set; requiring it keeps a stale header inert.
  assign apply = init_done && rx_done_tick && (state == LAST_ST) && b0.sync;

  always_comb begin
    dx     = {{(SW-9){b0.x_sign}}, b0.x_sign, b1};
    dy     = {{(SW-9){b0.y_sign}}, b0.y_sign, y_byte};
    sum_x  = $signed({2'b00, cursor_x}) + dx;
    sum_y  = $signed({2'b00, cursor_y}) - dy;
    next_x = clamp(sum_x, X_MAX);
    next_y = clamp(sum_y, Y_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_B0;
      b0        <= '0;
      b1        <= '0;
      cnt       <= '0;
      cursor_x  <= COORD_W'(INIT_X);
      cursor_y  <= COORD_W'(INIT_Y);
      buttons   <= '0;
      pkt_valid <= 1'b0;
      run_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      run_err   <= 1'b0;
      if (init_done) begin
        if (rx_done_tick) begin
          cnt <= '0;
          case (state)
            ST_B0: begin
              if (rx_dout[3]) begin
                b0    <= flags_t'(rx_dout);
                state <= ST_B1;
              end else begin
                run_err <= 1'b1;
              end
            end
            ST_B1: begin
              b1    <= rx_dout;
              state <= ST_B2;
            end
`ifdef PS2_MOUSE_WHEEL_EN
            ST_B2:   state <= ST_B3;
`endif
            default: state <= ST_B0;
          endcase
        end else if (state != ST_B0) begin
          if (cnt == CNT_LAST) begin
            state   <= ST_B0;
            cnt     <= '0;
            run_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        if (apply) begin
          pkt_valid <= 1'b1;
          buttons   <= {b0.middle, b0.right, b0.left};
          if (!b0.x_ovf) cursor_x <= next_x;
          if (!b0.y_ovf) cursor_y <= next_y;
        end
      end
    end
  end

`ifdef PS2_MOUSE_WHEEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      b2    <= '0;
      wheel <= '0;
    end else begin
      if (init_done && rx_done_tick && state == ST_B2) b2 <= rx_dout;
      if (apply) wheel <= wheel + {{4{rx_dout[3]}}, rx_dout[3:0]};
    end
  end
`else
  assign wheel = '0;
`endif

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker; follows PS2_MOUSE_WHEEL_EN for list and packet length.
module tb_ps2_mouse_tracker;

  localparam int unsigned TO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] din;
  logic       init_done;
  logic [9:0] cursor_x;
  logic [9:0] cursor_y;
  logic [2:0] buttons;
  logic       pkt_valid;
  logic       sync_err;
  logic [7:0] wheel;

  ps2_mouse_tracker #(
    .SCREEN_W(640), .SCREEN_H(480), .COORD_W(10),
    .INIT_X(100), .INIT_Y(100), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .din(din),
    .init_done(init_done), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .buttons(buttons), .pkt_valid(pkt_valid), .sync_err(sync_err), .wheel(wheel)
  );

  always #5 clk = ~clk;

`ifdef PS2_MOUSE_WHEEL_EN
  localparam int INIT_N = 21;
  localparam logic [8:0] INIT_LIST [INIT_N] = '{
    9'h1FF, 9'h0FA, 9'h0AA, 9'h000,
    9'h1F3, 9'h0FA, 9'h1C8, 9'h0FA, 9'h1F3, 9'h0FA, 9'h164, 9'h0FA,
    9'h1F3, 9'h0FA, 9'h150, 9'h0FA,
    9'h1F2, 9'h0FA, 9'h003, 9'h1F4, 9'h0FA};
  localparam logic [7:0] WHL_NEG1 = 8'hFF;
`else
  localparam int INIT_N = 6;
  localparam logic [8:0] INIT_LIST [INIT_N] = '{
    9'h1FF, 9'h0FA, 9'h0AA, 9'h000, 9'h1F4, 9'h0FA};
  localparam logic [7:0] WHL_NEG1 = 8'h00;
`endif

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
    logic [7:0] whl;
  } pkt_exp_t;

  pkt_exp_t   pkt_q[$];
  logic [7:0] wr_q[$];
  bit         sync_q[$];
  int         total = 0;
  int         bad = 0;
  logic       prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_ps2) begin
        check("wr_gap", 32'(prev_wr), 0);
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) check("wr_din", 32'(din), 32'(wr_q.pop_front()));
      end
      if (pkt_valid) begin
        check("pkt_expected", 32'(pkt_q.size() != 0), 1);
        if (pkt_q.size() != 0) begin
          pkt_exp_t e;
          e = pkt_q.pop_front();
          check("pkt_x", 32'(cursor_x), 32'(e.x));
          check("pkt_y", 32'(cursor_y), 32'(e.y));
          check("pkt_btn", 32'(buttons), 32'(e.btn));
          check("pkt_wheel", 32'(wheel), 32'(e.whl));
        end
      end
      if (sync_err) begin
        check("sync_expected", 32'(sync_q.size() != 0), 1);
        if (sync_q.size() != 0) void'(sync_q.pop_front());
      end
    end
    prev_wr <= wr_ps2;
  end

  task automatic push_pkt(input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] btn, input logic [7:0] whl);
    pkt_exp_t e;
    e.x = x; e.y = y; e.btn = btn; e.whl = whl;
    pkt_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dout = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // Bytes go out on consecutive cycles.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    @(negedge clk); rx_dout = b0; rx_done_tick = 1'b1;
    @(negedge clk); rx_dout = b1;
    @(negedge clk); rx_dout = b2;
`ifdef PS2_MOUSE_WHEEL_EN
    @(negedge clk); rx_dout = b3;
`else
    if (b3 != 8'h00) $display("note: wheel byte %0h unused in base build", b3);
`endif
    @(negedge clk); rx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_write(input logic [7:0] code);
    int unsigned n;
    n = 0;
    wr_q.push_back(code);
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ps2 && n < 100);
    check("wr_seen", 32'(wr_ps2), 1);
    repeat (3) @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic run_init();
    for (int i = 0; i < INIT_N; i++) begin
      logic [8:0] e;
      e = INIT_LIST[i];
      if (i == INIT_N - 1) check("init_done_before", 32'(init_done), 0);
      if (e[8]) wait_write(e[7:0]);
      else send_byte(e[7:0]);
    end
    @(negedge clk);
    check("init_done_after", 32'(init_done), 1);
  endtask

  initial begin
    rst = 1'b1;
    rx_done_tick = 1'b0;
    rx_dout = 8'h00;
    tx_idle = 1'b1;
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(cursor_x), 100);
    check("rst_y", 32'(cursor_y), 100);
    check("rst_buttons", 32'(buttons), 0);
    check("rst_wheel", 32'(wheel), 0);
    check("rst_din", 32'(din), 0);
    check("rst_wr", 32'(wr_ps2), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_strobes", 32'({pkt_valid, sync_err}), 0);
    rst = 1'b0;

    // Mismatched BAT reply restarts the list with a fresh FF write.
    wait_write(8'hFF);
    send_byte(8'hFA);
    sync_q.push_back(1'b1);
    send_byte(8'hFC);
    run_init();

    push_pkt(10'd105, 10'd97, 3'b001, 8'h00);
    send_pkt(8'h09, 8'h05, 8'h03, 8'h00);
    push_pkt(10'd2, 10'd352, 3'b000, 8'h00);
    send_pkt(8'h38, 8'h99, 8'h01, 8'h00);
    push_pkt(10'd2, 10'd478, 3'b000, 8'h00);
    send_pkt(8'h28, 8'h00, 8'h82, 8'h00);
    push_pkt(10'd0, 10'd478, 3'b000, 8'h00);
    send_pkt(8'h18, 8'hF0, 8'h00, 8'h00);
    push_pkt(10'd0, 10'd479, 3'b000, 8'h00);
    send_pkt(8'h28, 8'h00, 8'hF6, 8'h00);
    push_pkt(10'd7, 10'd479, 3'b010, 8'h00);
    send_pkt(8'h8A, 8'h07, 8'h05, 8'h00);
    push_pkt(10'd7, 10'd469, 3'b100, 8'h00);
    send_pkt(8'h4C, 8'h20, 8'h0A, 8'h00);

    // Resync: drop an unsynced header, then abandon a partial packet on timeout.
    sync_q.push_back(1'b1);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h10);
    sync_q.push_back(1'b1);
    repeat (TO + 10) @(negedge clk);
    check("resync_x", 32'(cursor_x), 7);
    check("resync_y", 32'(cursor_y), 469);
    push_pkt(10'd8, 10'd468, 3'b001, 8'h00);
    send_pkt(8'h09, 8'h01, 8'h01, 8'h00);

    push_pkt(10'd8, 10'd468, 3'b000, WHL_NEG1);
    send_pkt(8'h08, 8'h00, 8'h00, 8'h0F);

    // Reset mid-packet.
    send_byte(8'h08);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_x", 32'(cursor_x), 100);
    check("rst2_y", 32'(cursor_y), 100);
    check("rst2_buttons", 32'(buttons), 0);
    check("rst2_wheel", 32'(wheel), 0);
    check("rst2_init_done", 32'(init_done), 0);
    check("rst2_din", 32'(din), 0);
    rst = 1'b0;
    wait_write(8'hFF);

    repeat (5) @(negedge clk);
    check("wr_q_left", 32'(wr_q.size()), 0);
    check("pkt_q_left", 32'(pkt_q.size()), 0);
    check("sync_q_left", 32'(sync_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
